// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine. Non-memory ops pass straight
// through; aligned loads/stores run one bus transaction (IDLE->REQ->WAIT->DONE)
// while stalling the pipeline, with an 8-bit timeout that ends in a bus error.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_reg_wen,
  input  logic [4:0]  in_reg_waddr,
  input  logic [63:0] in_alu_res,
  input  logic [63:0] in_store_data,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        stall_o,
  output logic        out_valid,
  output logic        out_reg_wen,
  output logic [4:0]  out_reg_waddr,
  output logic [63:0] out_wdata,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [7:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        uns_q, we_q, wen_q, err_q;
  logic [4:0]  waddr_q;

  logic        mem_op, misal, start, timeout;
  logic [7:0]  mask;
  logic [63:0] sh, ld_data;

  // Decode the incoming instruction: misalignment, lane mask, transaction start
  always_comb begin
    mem_op = in_is_load | in_is_store;
    case (in_size)
      2'b01:   misal = in_alu_res[0];
      2'b10:   misal = |in_alu_res[1:0];
      2'b11:   misal = |in_alu_res[2:0];
      default: misal = 1'b0;
    endcase
    case (in_size)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    start   = (state_q == S_IDLE) && in_valid && mem_op && !misal;
    timeout = (cnt_q == 8'hFF);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a handshake in the timeout cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (bus_req_ready) state_d = S_WAIT;
              else if (timeout) state_d = S_DONE;
      S_WAIT: if (bus_resp_valid || timeout) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction context, timeout counter, error flag and captured load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (start) begin
      cnt_q   <= '0;
      addr_q  <= in_alu_res;
      wdata_q <= in_is_store ? (in_store_data << {in_alu_res[2:0], 3'b000}) : '0;
      wstrb_q <= in_is_store ? (mask << in_alu_res[2:0]) : '0;
      size_q  <= in_size;
      uns_q   <= in_unsigned;
      we_q    <= in_is_store;
      wen_q   <= in_reg_wen;
      waddr_q <= in_reg_waddr;
      err_q   <= 1'b0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      cnt_q <= cnt_q + 8'd1;
      if (timeout && !((state_q == S_REQ) ? bus_req_ready : bus_resp_valid))
        err_q <= 1'b1;
      if (state_q == S_WAIT && bus_resp_valid)
        rdata_q <= bus_resp_rdata;
    end
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    sh = rdata_q >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'b00:   ld_data = uns_q ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   ld_data = uns_q ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   ld_data = uns_q ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ld_data = sh;
    endcase
  end

  assign bus_req_we    = we_q;
  assign bus_req_addr  = {addr_q[63:3], 3'b000};
  assign bus_req_wdata = wdata_q;
  assign bus_req_wstrb = wstrb_q;

  // Outputs per state; DONE drives only latched values
  always_comb begin
    stall_o       = 1'b0;
    out_valid     = 1'b0;
    out_reg_wen   = 1'b0;
    out_reg_waddr = '0;
    out_wdata     = '0;
    misalign_o    = 1'b0;
    bus_err_o     = 1'b0;
    bus_req_valid = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        if (!mem_op) begin
          out_valid     = 1'b1;
          out_reg_wen   = in_reg_wen;
          out_reg_waddr = in_reg_waddr;
          out_wdata     = in_alu_res;
        end else if (misal) begin
          out_valid     = 1'b1;
          out_reg_waddr = in_reg_waddr;
          misalign_o    = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end
      S_REQ: begin
        stall_o       = 1'b1;
        bus_req_valid = 1'b1;
      end
      S_WAIT: stall_o = 1'b1;
      default: begin
        out_valid     = 1'b1;
        out_reg_waddr = waddr_q;
        if (err_q) begin
          bus_err_o = 1'b1;
        end else if (!we_q) begin
          out_reg_wen = wen_q;
          out_wdata   = ld_data;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change on the falling edge,
// outputs are sampled 1 time unit later.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_reg_wen, in_is_load, in_is_store, in_unsigned;
  logic [4:0]  in_reg_waddr;
  logic [63:0] in_alu_res, in_store_data;
  logic [1:0]  in_size;
  logic        stall_o, out_valid, out_reg_wen, misalign_o, bus_err_o;
  logic [4:0]  out_reg_waddr;
  logic [63:0] out_wdata;
  logic        bus_req_valid, bus_req_ready, bus_req_we;
  logic [63:0] bus_req_addr, bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_reg_wen(in_reg_wen), .in_reg_waddr(in_reg_waddr),
    .in_alu_res(in_alu_res), .in_store_data(in_store_data),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .stall_o(stall_o), .out_valid(out_valid), .out_reg_wen(out_reg_wen),
    .out_reg_waddr(out_reg_waddr), .out_wdata(out_wdata),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic ld, input logic st, input logic [1:0] sz,
                       input logic u, input logic [63:0] a, input logic [63:0] sd,
                       input logic wen, input logic [4:0] wa);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_size = sz;
    in_unsigned = u; in_alu_res = a; in_store_data = sd;
    in_reg_wen = wen; in_reg_waddr = wa;
  endtask

  task automatic clear_in();
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_size = 2'b00;
    in_unsigned = 1'b0; in_alu_res = '0; in_store_data = '0;
    in_reg_wen = 1'b0; in_reg_waddr = '0;
  endtask

  // Full load: issue, accept at once, respond next cycle; returns at the DONE sample point
  task automatic load_txn(input string tag, input logic [63:0] a, input logic [1:0] sz,
                          input logic u, input logic [63:0] rd);
    instr(1'b1, 1'b0, sz, u, a, '0, 1'b1, 5'd4);
    #1 chk({tag, " stall"}, {63'b0, stall_o}, 64'd1);
    @(negedge clk); bus_req_ready = 1'b1;
    #1 chk({tag, " addr"}, bus_req_addr, {a[63:3], 3'b000});
    @(negedge clk); bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = rd;
    @(negedge clk); bus_resp_valid = 1'b0;
    #1 chk({tag, " valid"}, {63'b0, out_valid}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0;
    rst_n = 1'b0;
    #2;
    chk("rst stall",  {63'b0, stall_o},       64'd0);
    chk("rst oval",   {63'b0, out_valid},     64'd0);
    chk("rst reqv",   {63'b0, bus_req_valid}, 64'd0);
    chk("rst addr",   bus_req_addr,           64'd0);
    @(negedge clk); rst_n = 1'b1;

    // LB 0x1003 signed: byte lane 3 = 0x80
    @(negedge clk);
    instr(1'b1, 1'b0, 2'b00, 1'b0, 64'h1003, '0, 1'b1, 5'd5);
    #1 chk("lb stall", {63'b0, stall_o}, 64'd1);
    chk("lb oval idle", {63'b0, out_valid}, 64'd0);
    @(negedge clk); bus_req_ready = 1'b1;
    #1 chk("lb reqv", {63'b0, bus_req_valid}, 64'd1);
    chk("lb addr", bus_req_addr, 64'h1000);
    chk("lb we", {63'b0, bus_req_we}, 64'd0);
    @(negedge clk); bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
    bus_resp_rdata = 64'h0000_0000_8000_0000;
    #1 chk("lb wait stall", {63'b0, stall_o}, 64'd1);
    chk("lb wait reqv", {63'b0, bus_req_valid}, 64'd0);
    @(negedge clk); bus_resp_valid = 1'b0;
    #1 chk("lb oval", {63'b0, out_valid}, 64'd1);
    chk("lb wdata", out_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb wen", {63'b0, out_reg_wen}, 64'd1);
    chk("lb waddr", {59'b0, out_reg_waddr}, 64'd5);
    chk("lb done stall", {63'b0, stall_o}, 64'd0);
    @(negedge clk); clear_in();
    #1 chk("lb after oval", {63'b0, out_valid}, 64'd0);

    // SH 0x2006, ready held off for 3 REQ cycles
    @(negedge clk);
    instr(1'b0, 1'b1, 2'b01, 1'b0, 64'h2006, 64'hABCD, 1'b1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("sh req stall", {63'b0, stall_o & bus_req_valid}, 64'd1);
    end
    chk("sh wstrb", {56'b0, bus_req_wstrb}, 64'hC0);
    chk("sh wdata", bus_req_wdata, 64'hABCD_0000_0000_0000);
    chk("sh we", {63'b0, bus_req_we}, 64'd1);
    @(negedge clk); bus_req_ready = 1'b1;
    @(negedge clk); bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
    #1 chk("sh wait stall", {63'b0, stall_o}, 64'd1);
    @(negedge clk); bus_resp_valid = 1'b0;
    #1 chk("sh oval", {63'b0, out_valid}, 64'd1);
    chk("sh wen", {63'b0, out_reg_wen}, 64'd0);
    chk("sh wdata out", out_wdata, 64'd0);
    chk("sh stall", {63'b0, stall_o}, 64'd0);
    @(negedge clk); clear_in();

    // Misaligned LW 0x1002
    @(negedge clk);
    instr(1'b1, 1'b0, 2'b10, 1'b0, 64'h1002, '0, 1'b1, 5'd6);
    #1 chk("mis flag", {63'b0, misalign_o}, 64'd1);
    chk("mis oval", {63'b0, out_valid}, 64'd1);
    chk("mis wen", {63'b0, out_reg_wen}, 64'd0);
    chk("mis stall", {63'b0, stall_o}, 64'd0);
    chk("mis reqv", {63'b0, bus_req_valid}, 64'd0);
    @(negedge clk); clear_in();
    #1 chk("mis after reqv", {63'b0, bus_req_valid | misalign_o}, 64'd0);

    // LD with no response: one REQ cycle then WAIT until the counter hits 255
    @(negedge clk);
    instr(1'b1, 1'b0, 2'b11, 1'b0, 64'h3000, '0, 1'b1, 5'd9);
    @(negedge clk); bus_req_ready = 1'b1;
    #1 chk("to reqv", {63'b0, bus_req_valid}, 64'd1);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk); bus_req_ready = 1'b0;
      #1;
      if (out_valid) begin n = i; break; end
    end
    chk("to cycles", 64'(n), 64'd256);
    chk("to err", {63'b0, bus_err_o}, 64'd1);
    chk("to wen", {63'b0, out_reg_wen}, 64'd0);
    @(negedge clk); clear_in(); bus_resp_valid = 1'b1; bus_resp_rdata = 64'h1234;
    #1 chk("to late oval", {63'b0, out_valid | bus_err_o | stall_o}, 64'd0);
    @(negedge clk); bus_resp_valid = 1'b0;
    #1 chk("to late2 oval", {63'b0, out_valid}, 64'd0);

    // Reset during WAIT abandons the load
    @(negedge clk);
    instr(1'b1, 1'b0, 2'b11, 1'b0, 64'h4000, '0, 1'b1, 5'd2);
    @(negedge clk); bus_req_ready = 1'b1;
    @(negedge clk); bus_req_ready = 1'b0;
    #1 chk("rw wait stall", {63'b0, stall_o}, 64'd1);
    @(negedge clk); clear_in(); rst_n = 1'b0;
    #1 chk("rw stall", {63'b0, stall_o | bus_req_valid | out_valid}, 64'd0);
    @(negedge clk); rst_n = 1'b1; bus_resp_valid = 1'b1; bus_resp_rdata = 64'h55;
    #1 chk("rw late oval", {63'b0, out_valid}, 64'd0);
    @(negedge clk); bus_resp_valid = 1'b0;
    #1 chk("rw late2", {63'b0, out_valid | stall_o}, 64'd0);

    // ADD then LWU back to back
    @(negedge clk);
    instr(1'b0, 1'b0, 2'b11, 1'b0, 64'h1234, '0, 1'b1, 5'd3);
    #1 chk("add oval", {63'b0, out_valid}, 64'd1);
    chk("add wdata", out_wdata, 64'h1234);
    chk("add wen", {63'b0, out_reg_wen}, 64'd1);
    chk("add waddr", {59'b0, out_reg_waddr}, 64'd3);
    chk("add stall", {63'b0, stall_o}, 64'd0);
    @(negedge clk);
    // Offset 0 picks the low word of the beat, offset 4 the high word
    load_txn("lwu8", 64'h8, 2'b10, 1'b1, 64'hFFFF_FFFF_0000_0000);
    chk("lwu8 wdata", out_wdata, 64'h0);
    @(negedge clk);
    load_txn("lwuC", 64'hC, 2'b10, 1'b1, 64'hFFFF_FFFF_0000_0000);
    chk("lwuC wdata", out_wdata, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    load_txn("lwC", 64'hC, 2'b10, 1'b0, 64'hFFFF_FFFF_0000_0000);
    chk("lwC wdata", out_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    load_txn("lh2", 64'h2, 2'b01, 1'b0, 64'h0000_0000_8001_0000);
    chk("lh2 wdata", out_wdata, 64'hFFFF_FFFF_FFFF_8001);
    @(negedge clk);
    load_txn("lbu7", 64'h7, 2'b00, 1'b1, 64'hAB00_0000_0000_0000);
    chk("lbu7 wdata", out_wdata, 64'hAB);
    @(negedge clk);
    load_txn("ldu", 64'h10, 2'b11, 1'b1, 64'h8000_0000_0000_0001);
    chk("ldu wdata", out_wdata, 64'h8000_0000_0000_0001);
    @(negedge clk); clear_in();
    #1 chk("end oval", {63'b0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
